// File: rtl/ysyx_23060136_wbu_trap_seq.sv
// Write-back trap sequencer: turns retiring ecall/ebreak/mret/csr-write events into
// dual-channel CSR writes and a fetch redirect. Option macro: YSYX_23060136_EBREAK_TRAP_EN.
module ysyx_23060136_wbu_trap_seq #(
   parameter int unsigned           BITS_W      = 64,
   parameter int unsigned           CSR_W       = 3,
   parameter logic [CSR_W-1:0]      IDX_MSTATUS = 'd0,
   parameter logic [CSR_W-1:0]      IDX_MTVEC   = 'd1,
   parameter logic [CSR_W-1:0]      IDX_MEPC    = 'd2,
   parameter logic [CSR_W-1:0]      IDX_MCAUSE  = 'd3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [BITS_W-1:0] in_pc,
   input  logic              in_is_ecall,
   input  logic              in_is_ebreak,
   input  logic              in_is_mret,
   input  logic              in_csr_wr,
   input  logic [CSR_W-1:0]  in_csr_idx,
   input  logic [BITS_W-1:0] in_csr_wdata,
   input  logic [BITS_W-1:0] in_mstatus,
   input  logic [BITS_W-1:0] in_mtvec,
   input  logic [BITS_W-1:0] in_mepc,
   output logic              CSRWr_1,
   output logic [CSR_W-1:0]  WBU_csr_rd_1,
   output logic [BITS_W-1:0] csr_busW_1,
   output logic              CSRWr_2,
   output logic [CSR_W-1:0]  WBU_csr_rd_2,
   output logic [BITS_W-1:0] csr_busW_2,
   output logic              redirect_valid,
   output logic [BITS_W-1:0] redirect_pc,
   output logic              halt
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_TRAP_W1,
      S_TRAP_W2
   } state_e;

   localparam logic [BITS_W-1:0] CAUSE_ECALL  = {{(BITS_W-4){1'b0}}, 4'd11};
   localparam logic [BITS_W-1:0] CAUSE_EBREAK = {{(BITS_W-4){1'b0}}, 4'd3};
   localparam logic [BITS_W-1:0] ALIGN_MASK   = ~{{(BITS_W-2){1'b0}}, 2'b11};

   state_e              state_q, state_d;
   logic [BITS_W-1:0]   mstatus_q, mstatus_d;
   logic [BITS_W-1:0]   mtvec_q, mtvec_d;

   logic                wr1_q, wr1_d;
   logic [CSR_W-1:0]    rd1_q, rd1_d;
   logic [BITS_W-1:0]   bus1_q, bus1_d;
   logic                wr2_q, wr2_d;
   logic [CSR_W-1:0]    rd2_q, rd2_d;
   logic [BITS_W-1:0]   bus2_q, bus2_d;
   logic                rv_q, rv_d;
   logic [BITS_W-1:0]   rpc_q, rpc_d;

   logic                accept;
   logic                take_trap;
   logic                do_mret;
   logic                do_csr;
   logic [BITS_W-1:0]   trap_cause;
   logic                halted;

   // mret: MIE <- MPIE, MPIE <- 1, MPP <- M
   function automatic logic [BITS_W-1:0] mret_mstatus(input logic [BITS_W-1:0] ms);
      logic [BITS_W-1:0] r;
      r        = ms;
      r[3]     = ms[7];
      r[7]     = 1'b1;
      r[12:11] = 2'b11;
      return r;
   endfunction

   // trap entry: MPIE <- MIE, MIE <- 0, MPP <- M
   function automatic logic [BITS_W-1:0] trap_mstatus(input logic [BITS_W-1:0] ms);
      logic [BITS_W-1:0] r;
      r        = ms;
      r[7]     = ms[3];
      r[3]     = 1'b0;
      r[12:11] = 2'b11;
      return r;
   endfunction

`ifdef YSYX_23060136_EBREAK_TRAP_EN
   assign halted     = 1'b0;
   assign halt       = 1'b0;
   assign take_trap  = accept & (in_is_ebreak | in_is_ecall);
   assign trap_cause = in_is_ebreak ? CAUSE_EBREAK : CAUSE_ECALL;
`else
   logic halt_q, halt_d;

   // ebreak ends simulation; the sequencer then refuses all work until reset
   assign halt_d     = halt_q | (accept & in_is_ebreak);
   assign halted     = halt_q;
   assign halt       = halt_q;
   assign take_trap  = accept & ~in_is_ebreak & in_is_ecall;
   assign trap_cause = CAUSE_ECALL;

   always_ff @(posedge clk) begin
      if (rst) halt_q <= 1'b0;
      else     halt_q <= halt_d;
   end
`endif

   assign in_ready = ~rst & (state_q == S_IDLE) & ~halted;
   assign accept   = in_valid & in_ready;
   assign do_mret  = accept & ~in_is_ebreak & ~in_is_ecall & in_is_mret;
   assign do_csr   = accept & ~in_is_ebreak & ~in_is_ecall & ~in_is_mret & in_csr_wr;

   always_comb begin
      state_d   = state_q;
      mstatus_d = mstatus_q;
      mtvec_d   = mtvec_q;
      wr1_d     = 1'b0;
      rd1_d     = '0;
      bus1_d    = '0;
      wr2_d     = 1'b0;
      rd2_d     = '0;
      bus2_d    = '0;
      rv_d      = 1'b0;
      rpc_d     = '0;

      unique case (state_q)
         S_IDLE: begin
            if (take_trap) begin
               state_d   = S_TRAP_W1;
               mstatus_d = in_mstatus;
               mtvec_d   = in_mtvec;
               wr1_d     = 1'b1;
               rd1_d     = IDX_MEPC;
               bus1_d    = in_pc;
               wr2_d     = 1'b1;
               rd2_d     = IDX_MCAUSE;
               bus2_d    = trap_cause;
            end else if (do_mret) begin
               wr1_d  = 1'b1;
               rd1_d  = IDX_MSTATUS;
               bus1_d = mret_mstatus(in_mstatus);
               rv_d   = 1'b1;
               rpc_d  = in_mepc;
            end else if (do_csr) begin
               wr1_d  = 1'b1;
               rd1_d  = in_csr_idx;
               bus1_d = in_csr_wdata;
            end
         end
         // outputs computed here appear while the FSM sits in TRAP_W2
         S_TRAP_W1: begin
            state_d = S_TRAP_W2;
            wr1_d   = 1'b1;
            rd1_d   = IDX_MSTATUS;
            bus1_d  = trap_mstatus(mstatus_q);
            rv_d    = 1'b1;
            rpc_d   = mtvec_q & ALIGN_MASK;
         end
         S_TRAP_W2: state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         mstatus_q <= '0;
         mtvec_q   <= '0;
         wr1_q     <= 1'b0;
         rd1_q     <= '0;
         bus1_q    <= '0;
         wr2_q     <= 1'b0;
         rd2_q     <= '0;
         bus2_q    <= '0;
         rv_q      <= 1'b0;
         rpc_q     <= '0;
      end else begin
         state_q   <= state_d;
         mstatus_q <= mstatus_d;
         mtvec_q   <= mtvec_d;
         wr1_q     <= wr1_d;
         rd1_q     <= rd1_d;
         bus1_q    <= bus1_d;
         wr2_q     <= wr2_d;
         rd2_q     <= rd2_d;
         bus2_q    <= bus2_d;
         rv_q      <= rv_d;
         rpc_q     <= rpc_d;
      end
   end

   assign CSRWr_1        = wr1_q;
   assign WBU_csr_rd_1   = rd1_q;
   assign csr_busW_1     = bus1_q;
   assign CSRWr_2        = wr2_q;
   assign WBU_csr_rd_2   = rd2_q;
   assign csr_busW_2     = bus2_q;
   assign redirect_valid = rv_q;
   assign redirect_pc    = rpc_q;

endmodule

// File: tb/tb_ysyx_23060136_wbu_trap_seq.sv
// Bench for the write-back trap sequencer: a per-cycle schedule of expected CSR writes
// plus directed vectors with literal expectations.
module tb_ysyx_23060136_wbu_trap_seq;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid, in_ready;
   logic [63:0] in_pc, in_csr_wdata, in_mstatus, in_mtvec, in_mepc;
   logic        in_is_ecall, in_is_ebreak, in_is_mret, in_csr_wr;
   logic [2:0]  in_csr_idx;
   logic        CSRWr_1, CSRWr_2, redirect_valid, halt;
   logic [2:0]  WBU_csr_rd_1, WBU_csr_rd_2;
   logic [63:0] csr_busW_1, csr_busW_2, redirect_pc;

   always #5 clk = ~clk;

   ysyx_23060136_wbu_trap_seq dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
      .in_is_ecall(in_is_ecall), .in_is_ebreak(in_is_ebreak), .in_is_mret(in_is_mret),
      .in_csr_wr(in_csr_wr), .in_csr_idx(in_csr_idx), .in_csr_wdata(in_csr_wdata),
      .in_mstatus(in_mstatus), .in_mtvec(in_mtvec), .in_mepc(in_mepc),
      .CSRWr_1(CSRWr_1), .WBU_csr_rd_1(WBU_csr_rd_1), .csr_busW_1(csr_busW_1),
      .CSRWr_2(CSRWr_2), .WBU_csr_rd_2(WBU_csr_rd_2), .csr_busW_2(csr_busW_2),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt(halt)
   );

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // expected output values visible after a given clock edge
   typedef struct packed {
      bit        w1;
      bit [2:0]  i1;
      bit [63:0] d1;
      bit        w2;
      bit [2:0]  i2;
      bit [63:0] d2;
      bit        rv;
      bit [63:0] rpc;
   } exp_t;

   exp_t sched [0:4095];
   int   cyc       = 0;
   int   busy_last = 0;
   bit   halted    = 1'b0;

   function automatic logic [63:0] m_mret(input logic [63:0] ms);
      return (ms & ~64'h1888) | 64'h1880 | (ms[7] ? 64'h8 : 64'h0);
   endfunction

   function automatic logic [63:0] m_trap(input logic [63:0] ms);
      return (ms & ~64'h1888) | 64'h1800 | (ms[3] ? 64'h80 : 64'h0);
   endfunction

   task automatic sched_trap(input int k, input logic [63:0] pc, input logic [63:0] ms,
                             input logic [63:0] mt, input logic [63:0] cause);
      sched[k].w1    = 1'b1; sched[k].i1 = 3'd2; sched[k].d1 = pc;
      sched[k].w2    = 1'b1; sched[k].i2 = 3'd3; sched[k].d2 = cause;
      sched[k+1].w1  = 1'b1; sched[k+1].i1 = 3'd0; sched[k+1].d1 = m_trap(ms);
      sched[k+1].rv  = 1'b1; sched[k+1].rpc = {mt[63:2], 2'b00};
      busy_last      = k + 1;
   endtask

   // model: an accepted event schedules its writes on the following edge(s)
   initial begin
      for (int i = 0; i < 4096; i++) sched[i] = '0;
      forever begin
         @(posedge clk);
         cyc++;
         if (rst) begin
            sched[cyc]   = '0;
            sched[cyc+1] = '0;
            busy_last    = 0;
            halted       = 1'b0;
         end else if (in_valid && !halted && (cyc - 1 > busy_last)) begin
            if (in_is_ebreak) begin
`ifdef YSYX_23060136_EBREAK_TRAP_EN
               sched_trap(cyc, in_pc, in_mstatus, in_mtvec, 64'd3);
`else
               halted = 1'b1;
`endif
            end else if (in_is_ecall) begin
               sched_trap(cyc, in_pc, in_mstatus, in_mtvec, 64'd11);
            end else if (in_is_mret) begin
               sched[cyc].w1  = 1'b1; sched[cyc].i1 = 3'd0; sched[cyc].d1 = m_mret(in_mstatus);
               sched[cyc].rv  = 1'b1; sched[cyc].rpc = in_mepc;
            end else if (in_csr_wr) begin
               sched[cyc].w1  = 1'b1; sched[cyc].i1 = in_csr_idx; sched[cyc].d1 = in_csr_wdata;
            end
         end
      end
   end

   // compare every cycle, just after the edge
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         e = sched[cyc];
         chk("m_ready", {63'd0, in_ready}, {63'd0, !rst && !halted && (cyc > busy_last)});
         chk("m_wr1", {63'd0, CSRWr_1}, {63'd0, e.w1});
         if (e.w1) begin
            chk("m_rd1", {61'd0, WBU_csr_rd_1}, {61'd0, e.i1});
            chk("m_bus1", csr_busW_1, e.d1);
         end
         chk("m_wr2", {63'd0, CSRWr_2}, {63'd0, e.w2});
         if (e.w2) begin
            chk("m_rd2", {61'd0, WBU_csr_rd_2}, {61'd0, e.i2});
            chk("m_bus2", csr_busW_2, e.d2);
         end
         chk("m_rv", {63'd0, redirect_valid}, {63'd0, e.rv});
         if (e.rv) chk("m_rpc", redirect_pc, e.rpc);
         chk("m_halt", {63'd0, halt}, {63'd0, halted});
      end
   end

   task automatic idle();
      in_valid = 0; in_is_ecall = 0; in_is_ebreak = 0; in_is_mret = 0; in_csr_wr = 0;
      in_csr_idx = '0; in_csr_wdata = '0; in_pc = '0;
      in_mstatus = '0; in_mtvec = '0; in_mepc = '0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      idle();
      rst = 1'b1;
      repeat (2) tick();
      chk("rst_ready", {63'd0, in_ready}, 64'd0);
      chk("rst_wr1", {63'd0, CSRWr_1}, 64'd0);
      chk("rst_bus1", csr_busW_1, 64'd0);
      chk("rst_rv", {63'd0, redirect_valid}, 64'd0);
      chk("rst_rpc", redirect_pc, 64'd0);
      chk("rst_halt", {63'd0, halt}, 64'd0);
      @(negedge clk); rst = 1'b0;
      #1 chk("rel_ready", {63'd0, in_ready}, 64'd1);

      // 1: plain csr write
      @(negedge clk);
      in_valid = 1; in_csr_wr = 1; in_csr_idx = 3'd1; in_csr_wdata = 64'h8000_0000;
      tick();
      chk("t1_wr1", {63'd0, CSRWr_1}, 64'd1);
      chk("t1_rd1", {61'd0, WBU_csr_rd_1}, 64'd1);
      chk("t1_bus1", csr_busW_1, 64'h8000_0000);
      chk("t1_wr2", {63'd0, CSRWr_2}, 64'd0);
      @(negedge clk); idle();
      tick();
      chk("t1_pulse", {63'd0, CSRWr_1}, 64'd0);

      // 2: ecall; request held through T+1 must be ignored
      @(negedge clk);
      in_valid = 1; in_is_ecall = 1; in_pc = 64'h8000_0010;
      in_mstatus = 64'hA_0000_1808; in_mtvec = 64'h8000_0101;
      tick();
      chk("t2_rd1", {61'd0, WBU_csr_rd_1}, 64'd2);
      chk("t2_bus1", csr_busW_1, 64'h8000_0010);
      chk("t2_rd2", {61'd0, WBU_csr_rd_2}, 64'd3);
      chk("t2_bus2", csr_busW_2, 64'd11);
      chk("t2_ready1", {63'd0, in_ready}, 64'd0);
      tick();
      chk("t2_rd1b", {61'd0, WBU_csr_rd_1}, 64'd0);
      chk("t2_ms", csr_busW_1, 64'hA_0000_1880);
      chk("t2_rv", {63'd0, redirect_valid}, 64'd1);
      chk("t2_rpc", redirect_pc, 64'h8000_0100);
      chk("t2_wr2", {63'd0, CSRWr_2}, 64'd0);
      chk("t2_ready2", {63'd0, in_ready}, 64'd0);
      @(negedge clk); idle();
      tick();
      chk("t2_ready3", {63'd0, in_ready}, 64'd1);
      chk("t2_rv_end", {63'd0, redirect_valid}, 64'd0);

      // 3: mret
      @(negedge clk);
      in_valid = 1; in_is_mret = 1; in_mstatus = 64'hA_0000_1880; in_mepc = 64'h8000_0014;
      tick();
      chk("t3_ms", csr_busW_1, 64'hA_0000_1888);
      chk("t3_rv", {63'd0, redirect_valid}, 64'd1);
      chk("t3_rpc", redirect_pc, 64'h8000_0014);
      chk("t3_ready", {63'd0, in_ready}, 64'd1);

      // 3b: mret outranks csr_wr
      @(negedge clk); idle();
      in_valid = 1; in_is_mret = 1; in_csr_wr = 1; in_csr_idx = 3'd5; in_csr_wdata = 64'h55;
      in_mstatus = 64'h88; in_mepc = 64'h8000_0044;
      tick();
      chk("t3b_rd1", {61'd0, WBU_csr_rd_1}, 64'd0);
      chk("t3b_ms", csr_busW_1, 64'h1888);

      // 4: ecall + csr_wr together
      @(negedge clk); idle();
      in_valid = 1; in_is_ecall = 1; in_csr_wr = 1; in_csr_idx = 3'd1; in_csr_wdata = 64'hdead;
      in_pc = 64'h8000_0020; in_mtvec = 64'h8000_0200;
      tick();
      chk("t4_rd1", {61'd0, WBU_csr_rd_1}, 64'd2);
      chk("t4_bus1", csr_busW_1, 64'h8000_0020);
      @(negedge clk); idle();
      tick();
      chk("t4_ms", csr_busW_1, 64'h1800);
      chk("t4_rpc", redirect_pc, 64'h8000_0200);
      tick();

      // 5: reset during TRAP_W1
      @(negedge clk);
      in_valid = 1; in_is_ecall = 1; in_pc = 64'h8000_0030; in_mstatus = 64'h8;
      in_mtvec = 64'h8000_0300;
      tick();
      chk("t5_wr1", {63'd0, CSRWr_1}, 64'd1);
      @(negedge clk); idle(); rst = 1'b1;
      tick();
      chk("t5_wr1_abort", {63'd0, CSRWr_1}, 64'd0);
      chk("t5_rv_abort", {63'd0, redirect_valid}, 64'd0);
      @(negedge clk); rst = 1'b0;
      tick();
      chk("t5_ready", {63'd0, in_ready}, 64'd1);
      chk("t5_rv_after", {63'd0, redirect_valid}, 64'd0);

      // 6: ebreak (ecall also raised, ebreak wins)
      @(negedge clk);
      in_valid = 1; in_is_ebreak = 1; in_is_ecall = 1; in_pc = 64'h8000_0040;
      in_mstatus = 64'h8; in_mtvec = 64'h8000_0303;
      tick();
`ifdef YSYX_23060136_EBREAK_TRAP_EN
      chk("t6_rd2", {61'd0, WBU_csr_rd_2}, 64'd3);
      chk("t6_cause", csr_busW_2, 64'd3);
      chk("t6_halt", {63'd0, halt}, 64'd0);
      @(negedge clk); idle();
      tick();
      chk("t6_ms", csr_busW_1, 64'h1880);
      chk("t6_rpc", redirect_pc, 64'h8000_0300);
      tick();
`else
      chk("t6_halt", {63'd0, halt}, 64'd1);
      chk("t6_wr1", {63'd0, CSRWr_1}, 64'd0);
      chk("t6_wr2", {63'd0, CSRWr_2}, 64'd0);
      chk("t6_rv", {63'd0, redirect_valid}, 64'd0);
      chk("t6_ready", {63'd0, in_ready}, 64'd0);
      @(negedge clk); idle();
      in_valid = 1; in_csr_wr = 1; in_csr_idx = 3'd4; in_csr_wdata = 64'h77;
      tick();
      chk("t6_blocked", {63'd0, CSRWr_1}, 64'd0);
      chk("t6_sticky", {63'd0, halt}, 64'd1);
      @(negedge clk); idle(); rst = 1'b1;
      tick();
      chk("t6_halt_rst", {63'd0, halt}, 64'd0);
      @(negedge clk); rst = 1'b0;
      tick();
      chk("t6_ready_rst", {63'd0, in_ready}, 64'd1);
`endif

      repeat (3) tick();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout actual=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
